instr_mem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory for the MIPS core, sitting between the program loader and the fetch stage. Supersedes the fixed 32-word, preloaded combinational instruction ROM. Adds:
- a runtime program-load port;
- a valid/ready fetch handshake with one-cycle registered read;
- per-word written flags;
- out-of-range and unwritten-word detection, with a NOP substituted;
- a LOAD/RUN/DRAIN mode state machine.

---
 rtl/instr_mem_pkg.sv | 17 +
 rtl/instr_mem_sync_if.sv | 53 +++++
 rtl/imem_array.sv | 80 ++++++++
 rtl/instr_mem_sync.sv | 141 ++++++++++++++
 tb/tb_instr_mem_sync.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
// Shared types and defaults for the synchronous instruction memory slice.
//   imem_state_t      : operating mode of the memory (LOAD / RUN / DRAIN)
//   NOP_WORD_DEFAULT  : instruction word substituted on a fetch error
// ---------------------------------------------------------------------------
package instr_mem_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_sync_if.sv
// ---------------------------------------------------------------------------
// instr_mem_sync_if
// Bundles the program-load port, the fetch request port and the fetch
// response port of instr_mem_sync.
//   master : loader / fetch stage side (drives requests, consumes responses)
//   slave  : memory side
// Load   : ld_en, ld_valid, ld_addr, ld_data -> ld_ready, ld_err, ld_count
// Fetch  : fetch_req, fetch_addr -> fetch_ready
// Resp   : instr_valid, instr, instr_addr, instr_err <- instr_ready
// Status : mode_run
// ---------------------------------------------------------------------------
interface instr_mem_sync_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);

    logic              ld_en;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_err;
    logic [ADDR_W:0]   ld_count;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_err;

    logic              mode_run;

    modport master (
        output ld_en, ld_valid, ld_addr, ld_data,
        output fetch_req, fetch_addr, instr_ready,
        input  ld_ready, ld_err, ld_count,
        input  fetch_ready, instr_valid, instr, instr_addr, instr_err,
        input  mode_run
    );

    modport slave (
        input  ld_en, ld_valid, ld_addr, ld_data,
        input  fetch_req, fetch_addr, instr_ready,
        output ld_ready, ld_err, ld_count,
        output fetch_ready, instr_valid, instr, instr_addr, instr_err,
        output mode_run
    );

endinterface

// File: rtl/imem_array.sv
// ---------------------------------------------------------------------------
// imem_array
// DEPTH x DATA_W instruction storage with a per-word "written" flag.
// One synchronous write port and one synchronous read port. The read port
// substitutes NOP_WORD and raises rd_err when the address is out of range or
// the word was never written; the read register holds while rd_en is low.
//   clk, rst_n       : clock, asynchronous active-low reset (flags, read reg)
//   wr_en/addr/data  : write strobe, word address, word
//   wr_oob           : combinational, wr_addr >= DEPTH (write is dropped)
//   rd_en/addr       : read strobe, word address
//   rd_data, rd_err  : registered read word and error flag
// ---------------------------------------------------------------------------
module imem_array
    import instr_mem_pkg::*;
#(
    parameter int                ADDR_W   = 15,
    parameter int                DEPTH    = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_oob,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  wr_flag;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              rd_hit;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    // Compare with one extra bit so DEPTH == 2^ADDR_W is representable.
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];
    assign wr_oob      = !wr_in_range;
    assign rd_hit      = rd_in_range && wr_flag[rd_idx];

    // Storage is deliberately not reset; the flags decide what is trusted.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Flags are sticky across reloads; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_flag <= '0;
        end else if (wr_en && wr_in_range) begin
            wr_flag[wr_idx] <= 1'b1;
        end
    end

    // Read stage boundary: word and error registered on accept only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= NOP_WORD;
            rd_err  <= 1'b0;
        end else if (rd_en) begin
            rd_data <= rd_hit ? mem[rd_idx] : NOP_WORD;
            rd_err  <= !rd_hit;
        end
    end

endmodule

// File: rtl/instr_mem_sync.sv
// ---------------------------------------------------------------------------
// instr_mem_sync
// Synchronous-read instruction memory between the program loader and the
// fetch stage. A LOAD/RUN/DRAIN mode machine makes loading and fetching
// mutually exclusive, so no write-to-read bypass is needed.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : instr_mem_sync_if.slave (load port, fetch port, response port,
//           mode_run status)
// ---------------------------------------------------------------------------
module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int                ADDR_W   = 15,
    parameter int                DEPTH    = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_mem_sync_if.slave  bus
);

    localparam logic [ADDR_W:0] LD_MAX = {1'b1, {ADDR_W{1'b0}}};

    imem_state_t       state_q;
    imem_state_t       state_d;
    logic              ld_rdy;
    logic              fetch_rdy;
    logic              ld_wr;
    logic              ld_oob;
    logic              fetch_fire;
    logic              enter_load;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] rd_data_p1;
    logic              rd_err_p1;

    logic [ADDR_W:0]   ld_count_q;
    logic              ld_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_rdy    = 1'b0;
        fetch_rdy = 1'b0;
        case (state_q)
            LOAD: begin
                ld_rdy = 1'b1;
                // A write presented this cycle completes before leaving.
                if (!bus.ld_en && !bus.ld_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                fetch_rdy = !vld_p1 || bus.instr_ready;
                if (bus.ld_en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!vld_p1 || bus.instr_ready) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign ld_wr      = ld_rdy && bus.ld_valid;
    assign fetch_fire = fetch_rdy && bus.fetch_req;
    assign enter_load = (state_q != LOAD) && (state_d == LOAD);

    // Load accounting: count accepted words, pulse on dropped addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_count_q <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            ld_err_q <= ld_wr && ld_oob;
            if (enter_load) begin
                ld_count_q <= '0;
            end else if (ld_wr && !ld_oob && (ld_count_q != LD_MAX)) begin
                ld_count_q <= ld_count_q + 1'b1;
            end
        end
    end

    imem_array #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .NOP_WORD (NOP_WORD)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ld_wr),
        .wr_addr (bus.ld_addr),
        .wr_data (bus.ld_data),
        .wr_oob  (ld_oob),
        .rd_en   (fetch_fire),
        .rd_addr (bus.fetch_addr),
        .rd_data (rd_data_p1),
        .rd_err  (rd_err_p1)
    );

    // Response stage boundary: valid and address travel with the array's
    // registered word; a same-cycle consume and accept keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
        end else if (fetch_fire) begin
            vld_p1  <= 1'b1;
            addr_p1 <= bus.fetch_addr;
        end else if (bus.instr_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.ld_ready    = ld_rdy;
    assign bus.ld_err      = ld_err_q;
    assign bus.ld_count    = ld_count_q;
    assign bus.fetch_ready = fetch_rdy;
    assign bus.instr_valid = vld_p1;
    assign bus.instr       = rd_data_p1;
    assign bus.instr_addr  = addr_p1;
    assign bus.instr_err   = rd_err_p1;
    assign bus.mode_run    = (state_q == RUN);

endmodule

// File: tb/tb_instr_mem_sync.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_sync
// Bench for instr_mem_sync: one instance at DEPTH=32/ADDR_W=15 tracked by a
// behavioural model every cycle, one at DEPTH=1024/ADDR_W=10 checked with
// literal expectations.
// ---------------------------------------------------------------------------
module tb_instr_mem_sync;

    localparam int          A_DEPTH = 32;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] prog [4];

    instr_mem_sync_if #(.ADDR_W(15), .DATA_W(32)) a_if ();
    instr_mem_sync_if #(.ADDR_W(10), .DATA_W(32)) b_if ();

    instr_mem_sync #(
        .ADDR_W(15), .DEPTH(32), .DATA_W(32), .NOP_WORD(32'h0000_0000)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    instr_mem_sync #(
        .ADDR_W(10), .DEPTH(1024), .DATA_W(32), .NOP_WORD(32'h0000_0000)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model of instance A ----------------
    localparam int M_LOAD  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    int          m_mode   = M_LOAD;
    logic [31:0] m_mem [A_DEPTH];
    bit          m_written [A_DEPTH];
    int          m_count  = 0;
    bit          m_lderr  = 1'b0;
    bit          m_vld    = 1'b0;
    logic [31:0] m_instr  = NOP;
    int          m_addr   = 0;
    bit          m_err    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = M_LOAD;
            m_count = 0;
            m_lderr = 1'b0;
            m_vld   = 1'b0;
            m_instr = NOP;
            m_addr  = 0;
            m_err   = 1'b0;
            foreach (m_written[i]) m_written[i] = 1'b0;
        end else begin
            bit take;
            bit was_vld;
            int fa;
            int la;
            fa      = int'(a_if.fetch_addr);
            la      = int'(a_if.ld_addr);
            was_vld = m_vld;
            take    = (m_mode == M_RUN) && (!m_vld || a_if.instr_ready) && a_if.fetch_req;
            m_lderr = 1'b0;
            if (m_mode == M_LOAD && a_if.ld_valid) begin
                if (la < A_DEPTH) begin
                    m_mem[la]     = a_if.ld_data;
                    m_written[la] = 1'b1;
                    if (m_count < (1 << 15)) m_count++;
                end else begin
                    m_lderr = 1'b1;
                end
            end
            if (take) begin
                m_vld  = 1'b1;
                m_addr = fa;
                if (fa < A_DEPTH && m_written[fa]) begin
                    m_instr = m_mem[fa];
                    m_err   = 1'b0;
                end else begin
                    m_instr = NOP;
                    m_err   = 1'b1;
                end
            end else if (a_if.instr_ready) begin
                m_vld = 1'b0;
            end
            case (m_mode)
                M_LOAD:  if (!a_if.ld_en && !a_if.ld_valid) m_mode = M_RUN;
                M_RUN:   if (a_if.ld_en) m_mode = M_DRAIN;
                default: if (!was_vld || a_if.instr_ready) begin
                    m_mode  = M_LOAD;
                    m_count = 0;
                end
            endcase
        end
    end

    // Compare instance A against the model on every falling edge.
    always @(negedge clk) begin
        chk("a.ld_ready",    64'(a_if.ld_ready),    64'(m_mode == M_LOAD));
        chk("a.fetch_ready", 64'(a_if.fetch_ready), 64'((m_mode == M_RUN) && (!m_vld || a_if.instr_ready)));
        chk("a.mode_run",    64'(a_if.mode_run),    64'(m_mode == M_RUN));
        chk("a.instr_valid", 64'(a_if.instr_valid), 64'(m_vld));
        chk("a.ld_err",      64'(a_if.ld_err),      64'(m_lderr));
        chk("a.ld_count",    64'(a_if.ld_count),    64'(m_count));
        if (m_vld) begin
            chk("a.instr",      64'(a_if.instr),      64'(m_instr));
            chk("a.instr_addr", 64'(a_if.instr_addr), 64'(m_addr));
            chk("a.instr_err",  64'(a_if.instr_err),  64'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        prog[0] = 32'h3C01_0001;
        prog[1] = 32'h2022_0003;
        prog[2] = 32'h0000_0020;
        prog[3] = 32'h1000_FFFF;

        a_if.ld_en = 1'b1;  a_if.ld_valid = 1'b0; a_if.ld_addr = '0; a_if.ld_data = '0;
        a_if.fetch_req = 1'b0; a_if.fetch_addr = '0; a_if.instr_ready = 1'b0;
        b_if.ld_en = 1'b1;  b_if.ld_valid = 1'b0; b_if.ld_addr = '0; b_if.ld_data = '0;
        b_if.fetch_req = 1'b0; b_if.fetch_addr = '0; b_if.instr_ready = 1'b0;

        step();
        chk("rst.ld_ready",    64'(a_if.ld_ready),    64'd1);
        chk("rst.ld_err",      64'(a_if.ld_err),      64'd0);
        chk("rst.ld_count",    64'(a_if.ld_count),    64'd0);
        chk("rst.fetch_ready", 64'(a_if.fetch_ready), 64'd0);
        chk("rst.instr_valid", 64'(a_if.instr_valid), 64'd0);
        chk("rst.instr",       64'(a_if.instr),       64'h0);
        chk("rst.instr_addr",  64'(a_if.instr_addr),  64'd0);
        chk("rst.instr_err",   64'(a_if.instr_err),   64'd0);
        chk("rst.mode_run",    64'(a_if.mode_run),    64'd0);
        rst_n = 1'b1;
        step();

        // Load program and run back-to-back fetches.
        for (int i = 0; i < 4; i++) begin
            a_if.ld_valid = 1'b1; a_if.ld_addr = 15'(i); a_if.ld_data = prog[i];
            step();
        end
        a_if.ld_valid = 1'b0; a_if.ld_en = 1'b0;
        step();
        chk("s1.ld_count", 64'(a_if.ld_count), 64'd4);
        chk("s1.mode_run", 64'(a_if.mode_run), 64'd1);
        a_if.instr_ready = 1'b1; a_if.fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.fetch_addr = 15'(i);
            step();
            chk("s1.valid", 64'(a_if.instr_valid), 64'd1);
            chk("s1.instr", 64'(a_if.instr),       64'(prog[i]));
            chk("s1.addr",  64'(a_if.instr_addr),  64'(i));
            chk("s1.err",   64'(a_if.instr_err),   64'd0);
        end

        // Unwritten and out-of-range fetches.
        a_if.fetch_addr = 15'd7;
        step();
        chk("s2.unwr.instr", 64'(a_if.instr),     64'h0);
        chk("s2.unwr.err",   64'(a_if.instr_err), 64'd1);
        a_if.fetch_addr = 15'd40;
        step();
        chk("s2.oob.err",  64'(a_if.instr_err),  64'd1);
        chk("s2.oob.addr", 64'(a_if.instr_addr), 64'd40);
        a_if.fetch_req = 1'b0;
        step();
        chk("s2.drained", 64'(a_if.instr_valid), 64'd0);

        // Backpressure: response held for 3 cycles.
        a_if.fetch_req = 1'b1; a_if.fetch_addr = 15'd2; a_if.instr_ready = 1'b0;
        step();
        chk("s3.first", 64'(a_if.instr), 64'(prog[2]));
        a_if.fetch_addr = 15'd3;
        repeat (3) begin
            step();
            chk("s3.hold.instr", 64'(a_if.instr),       64'(prog[2]));
            chk("s3.hold.addr",  64'(a_if.instr_addr),  64'd2);
            chk("s3.hold.frdy",  64'(a_if.fetch_ready), 64'd0);
        end
        a_if.instr_ready = 1'b1;
        #1;
        chk("s3.frdy", 64'(a_if.fetch_ready), 64'd1);
        step();
        chk("s3.next.instr", 64'(a_if.instr),      64'(prog[3]));
        chk("s3.next.addr",  64'(a_if.instr_addr), 64'd3);

        // Drain with a pending response.
        a_if.fetch_req = 1'b0; a_if.instr_ready = 1'b0; a_if.ld_en = 1'b1;
        step();
        chk("s4.drain.run",   64'(a_if.mode_run),    64'd0);
        chk("s4.drain.ldrdy", 64'(a_if.ld_ready),    64'd0);
        chk("s4.drain.frdy",  64'(a_if.fetch_ready), 64'd0);
        a_if.fetch_req = 1'b1; a_if.fetch_addr = 15'd0;
        step();
        chk("s4.drain.hold",  64'(a_if.instr_valid), 64'd1);
        chk("s4.drain.addr",  64'(a_if.instr_addr),  64'd3);
        a_if.instr_ready = 1'b1;
        step();
        chk("s4.load.ldrdy",  64'(a_if.ld_ready),    64'd1);
        chk("s4.load.valid",  64'(a_if.instr_valid), 64'd0);
        chk("s4.load.count",  64'(a_if.ld_count),    64'd0);
        a_if.fetch_req = 1'b0;

        // Reload address 1, then a dropped out-of-range load.
        a_if.ld_valid = 1'b1; a_if.ld_addr = 15'd1; a_if.ld_data = 32'hDEAD_BEEF;
        step();
        chk("s4.rl.count", 64'(a_if.ld_count), 64'd1);
        a_if.ld_addr = 15'd40; a_if.ld_data = 32'h5555_5555;
        step();
        chk("s4.lderr.pulse", 64'(a_if.ld_err),   64'd1);
        chk("s4.lderr.count", 64'(a_if.ld_count), 64'd1);
        a_if.ld_valid = 1'b0;
        step();
        chk("s4.lderr.end", 64'(a_if.ld_err), 64'd0);
        a_if.ld_en = 1'b0;
        step();
        a_if.fetch_req = 1'b1; a_if.fetch_addr = 15'd1;
        step();
        chk("s4.reload.instr", 64'(a_if.instr),     64'hDEAD_BEEF);
        chk("s4.reload.err",   64'(a_if.instr_err), 64'd0);
        a_if.fetch_addr = 15'd0;
        step();
        chk("s4.keep.instr", 64'(a_if.instr), 64'(prog[0]));
        a_if.fetch_addr = 15'd2;
        step();

        // Asynchronous reset mid-stream.
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5.rst.valid", 64'(a_if.instr_valid), 64'd0);
        chk("s5.rst.run",   64'(a_if.mode_run),    64'd0);
        chk("s5.rst.ldrdy", 64'(a_if.ld_ready),    64'd1);
        a_if.fetch_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("s5.run", 64'(a_if.mode_run), 64'd1);
        a_if.fetch_req = 1'b1; a_if.fetch_addr = 15'd0;
        step();
        chk("s5.unwr.err",   64'(a_if.instr_err), 64'd1);
        chk("s5.unwr.instr", 64'(a_if.instr),     64'h0);
        a_if.fetch_req = 1'b0;
        step();

        // Instance B: DEPTH = 1024, ADDR_W = 10.
        for (int i = 0; i < 4; i++) begin
            b_if.ld_valid = 1'b1; b_if.ld_addr = 10'(i); b_if.ld_data = prog[i];
            step();
        end
        chk("b.count4", 64'(b_if.ld_count), 64'd4);
        b_if.ld_addr = 10'd1000; b_if.ld_data = 32'h0000_1234;
        step();
        chk("b.ld1000.err",   64'(b_if.ld_err),   64'd0);
        chk("b.ld1000.count", 64'(b_if.ld_count), 64'd5);
        b_if.ld_valid = 1'b0; b_if.ld_en = 1'b0;
        step();
        chk("b.run", 64'(b_if.mode_run), 64'd1);
        b_if.instr_ready = 1'b1; b_if.fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_if.fetch_addr = 10'(i);
            step();
            chk("b.valid", 64'(b_if.instr_valid), 64'd1);
            chk("b.instr", 64'(b_if.instr),       64'(prog[i]));
            chk("b.addr",  64'(b_if.instr_addr),  64'(i));
            chk("b.err",   64'(b_if.instr_err),   64'd0);
        end
        b_if.fetch_addr = 10'd1000;
        step();
        chk("b.f1000.instr", 64'(b_if.instr),     64'h0000_1234);
        chk("b.f1000.err",   64'(b_if.instr_err), 64'd0);
        b_if.fetch_addr = 10'd1023;
        step();
        chk("b.f1023.err",   64'(b_if.instr_err), 64'd1);
        chk("b.f1023.instr", 64'(b_if.instr),     64'h0);
        b_if.fetch_req = 1'b0;
        step();
        chk("b.idle",  64'(b_if.instr_valid), 64'd0);
        chk("b.count", 64'(b_if.ld_count),    64'd5);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
